// File: rtl/vga_pkg.sv
// Shared VGA definitions: frame-fetch FSM state and default visible timing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fb_state_t;

    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;

endpackage

// File: rtl/vga_fb_prefetch_fifo.sv
// Synchronous prefetch FIFO whose output comes straight from the storage registers.
// Latency: a push is visible at the output on the cycle after it is written.
// Backpressure: the caller never pushes when full or pops when empty; the output holds while not popped.
module vga_fb_prefetch_fifo #(
    parameter int W     = 13,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               out_data,
    output logic                       out_vld,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= push_data;
    end

    assign out_vld  = (count != '0);
    // Storage is not reset, so mask it until something has been written.
    assign out_data = out_vld ? mem[rd_ptr] : '0;

endmodule

// File: rtl/vga_fb_reader.sv
// Frame-buffer SRAM scheduler: host writes plus raster-order display prefetch into the line buffer.
// Latency: read issued at t, FIFO write at t+1, line_buffer_vld from t+2; host grant is same-cycle.
// Backpressure: reads stop once fifo_count+inflight reaches PF_DEPTH; output holds while vld && !rdy.
module vga_fb_reader #(
    parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
    parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
    parameter int RGB_SIZE  = 12,
    parameter int AW        = 19,
    parameter int PF_DEPTH  = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  fb_enable,
    input  logic                  host_req,
    input  logic [AW-1:0]         host_addr,
    input  logic [RGB_SIZE-1:0]   host_wdata,
    output logic                  host_gnt,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [RGB_SIZE-1:0]   mem_wdata,
    input  logic [RGB_SIZE-1:0]   mem_rdata,
    output logic [RGB_SIZE:0]     line_buffer_data,
    output logic                  line_buffer_vld,
    input  logic                  line_buffer_rdy
);

    import vga_pkg::fb_state_t;
    import vga_pkg::IDLE;
    import vga_pkg::FETCH;

    localparam int XW = $clog2(H_DISPLAY + 1);
    localparam int YW = $clog2(V_DISPLAY + 1);
    localparam int CW = $clog2(PF_DEPTH) + 1;

    localparam logic [XW-1:0] X_LAST     = XW'(H_DISPLAY - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(V_DISPLAY - 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(PF_DEPTH);

    fb_state_t     state_q, state_d;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [AW-1:0] addr_q;
    logic          inflight_q;
    logic          sof_q;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] credit;
    logic          disp_can;
    logic          urgent;
    logic          disp_rd;
    logic          last_pix;

    // Credit covers the read whose data is still on mem_rdata, so a push never overflows.
    assign credit   = fifo_count + {{(CW-1){1'b0}}, inflight_q};
    assign disp_can = !sys_rst && (state_q == FETCH) && (credit < CREDIT_MAX);
    assign urgent   = (credit <= CW'(1));
    assign host_gnt = !sys_rst && host_req && !(disp_can && urgent);
    assign disp_rd  = disp_can && !host_gnt;
    assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

    assign mem_en    = host_gnt || disp_rd;
    assign mem_we    = host_gnt;
    assign mem_addr  = host_gnt ? host_addr : (disp_rd ? addr_q : '0);
    assign mem_wdata = host_gnt ? host_wdata : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fb_enable) state_d = FETCH;
            FETCH:   if (disp_rd && last_pix && !fb_enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            sof_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= disp_rd;
            sof_q      <= disp_rd && (x_q == '0) && (y_q == '0);
            if (disp_rd) begin
                if (last_pix) begin
                    x_q    <= '0;
                    y_q    <= '0;
                    addr_q <= '0;
                end else if (x_q == X_LAST) begin
                    x_q    <= '0;
                    y_q    <= y_q + 1'b1;
                    addr_q <= addr_q + 1'b1;
                end else begin
                    x_q    <= x_q + 1'b1;
                    addr_q <= addr_q + 1'b1;
                end
            end
        end
    end

    vga_fb_prefetch_fifo #(
        .W     (RGB_SIZE + 1),
        .DEPTH (PF_DEPTH)
    ) u_prefetch_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (inflight_q),
        .push_data ({sof_q, mem_rdata}),
        .pop       (line_buffer_vld && line_buffer_rdy),
        .out_data  (line_buffer_data),
        .out_vld   (line_buffer_vld),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader on a 4x2 frame; the SRAM model returns data = address.
module tb_vga_fb_reader;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        fb_enable;
    logic        host_req;
    logic [2:0]  host_addr;
    logic [11:0] host_wdata;
    logic        host_gnt;
    logic        mem_en;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [12:0] line_buffer_data;
    logic        line_buffer_vld;
    logic        line_buffer_rdy;

    int checks = 0;
    int errors = 0;

    vga_fb_reader #(
        .H_DISPLAY (4),
        .V_DISPLAY (2),
        .RGB_SIZE  (12),
        .AW        (3),
        .PF_DEPTH  (4)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .fb_enable        (fb_enable),
        .host_req         (host_req),
        .host_addr        (host_addr),
        .host_wdata       (host_wdata),
        .host_gnt         (host_gnt),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .line_buffer_data (line_buffer_data),
        .line_buffer_vld  (line_buffer_vld),
        .line_buffer_rdy  (line_buffer_rdy)
    );

    always #5 sys_clk = ~sys_clk;

    // Read data is valid one cycle after the strobe; anything else returns a marker value.
    always @(posedge sys_clk) begin
        if (mem_en && !mem_we) mem_rdata <= {9'b0, mem_addr};
        else                   mem_rdata <= 12'hABC;
    end

    function automatic logic [12:0] pix(input int k);
        logic [2:0] a;
        a = 3'(k % 8);
        return {(a == 3'd0), 9'b0, a};
    endfunction

    // Ends at a falling edge with reset just released: that cycle is the first post-reset cycle.
    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1; fb_enable = 1'b0; host_req = 1'b0;
        host_addr = 3'd0; host_wdata = 12'd0; line_buffer_rdy = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; fb_enable = 1'b0; host_req = 1'b0;
        host_addr = 3'd0; host_wdata = 12'd0; line_buffer_rdy = 1'b0;
        repeat (3) @(negedge sys_clk);
        #1;
        checks++; if (line_buffer_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", line_buffer_vld); end
        checks++; if (line_buffer_data !== 13'd0) begin errors++; $display("FAIL reset_data got %h exp 0", line_buffer_data); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b exp 0", mem_en); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_addr !== 3'd0) begin errors++; $display("FAIL reset_mem_addr got %0d exp 0", mem_addr); end
        checks++; if (mem_wdata !== 12'd0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL reset_host_gnt got %b exp 0", host_gnt); end
    endtask

    task automatic test_free_run();
        do_reset();
        fb_enable = 1'b1; line_buffer_rdy = 1'b1;
        #1;
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL free_idle_en got %b exp 0", mem_en); end
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk); #1;
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 3'(i % 8)) begin
                errors++; $display("FAIL free_read cyc %0d got en=%b we=%b addr=%0d exp en=1 we=0 addr=%0d", i, mem_en, mem_we, mem_addr, i % 8);
            end
            checks++;
            if (i < 2) begin
                if (line_buffer_vld !== 1'b0) begin errors++; $display("FAIL free_early_vld cyc %0d got %b exp 0", i, line_buffer_vld); end
            end else if (line_buffer_vld !== 1'b1 || line_buffer_data !== pix(i - 2)) begin
                errors++; $display("FAIL free_data cyc %0d got vld=%b data=%h exp vld=1 data=%h", i, line_buffer_vld, line_buffer_data, pix(i - 2));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fb_enable = 1'b1; line_buffer_rdy = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge sys_clk); #1;
            checks++;
            if (i <= 4) begin
                if (mem_en !== 1'b1 || mem_addr !== 3'(i - 1)) begin
                    errors++; $display("FAIL bp_read cyc %0d got en=%b addr=%0d exp en=1 addr=%0d", i, mem_en, mem_addr, i - 1);
                end
            end else if (mem_en !== 1'b0) begin
                errors++; $display("FAIL bp_stall cyc %0d got en=%b exp 0", i, mem_en);
            end
            checks++;
            if (i < 3) begin
                if (line_buffer_vld !== 1'b0) begin errors++; $display("FAIL bp_early_vld cyc %0d got %b exp 0", i, line_buffer_vld); end
            end else if (line_buffer_vld !== 1'b1 || line_buffer_data !== pix(0)) begin
                errors++; $display("FAIL bp_hold cyc %0d got vld=%b data=%h exp vld=1 data=%h", i, line_buffer_vld, line_buffer_data, pix(0));
            end
        end
        for (int j = 0; j < 12; j++) begin
            @(negedge sys_clk);
            line_buffer_rdy = 1'b1;
            #1;
            if (j == 0) begin
                checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL bp_release_en got %b exp 0", mem_en); end
            end
            checks++;
            if (line_buffer_vld !== 1'b1 || line_buffer_data !== pix(j)) begin
                errors++; $display("FAIL bp_drain idx %0d got vld=%b data=%h exp vld=1 data=%h", j, line_buffer_vld, line_buffer_data, pix(j));
            end
        end
    endtask

    task automatic test_host_arb();
        logic [8:0] gnt_tab;
        logic [8:0] vld_tab;
        int         pk;
        int         rd;
        gnt_tab = 9'b100100111;
        vld_tab = 9'b101101111;
        pk = 0;
        rd = 4;
        do_reset();
        fb_enable = 1'b1; line_buffer_rdy = 1'b0;
        repeat (6) @(negedge sys_clk);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge sys_clk);
            host_req = 1'b1; host_addr = 3'(i + 1); host_wdata = 12'h500 + 12'(i);
            #1;
            checks++;
            if (host_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 3'(i + 1) || mem_wdata !== 12'h500 + 12'(i)) begin
                errors++; $display("FAIL host_full cyc %0d got gnt=%b en=%b we=%b addr=%0d wdata=%h exp 1 1 1 %0d %h", i, host_gnt, mem_en, mem_we, mem_addr, mem_wdata, i + 1, 12'h500 + 12'(i));
            end
        end
        for (int r = 0; r < 9; r++) begin
            @(negedge sys_clk);
            line_buffer_rdy = 1'b1;
            #1;
            checks++;
            if (host_gnt !== gnt_tab[r]) begin
                errors++; $display("FAIL arb_gnt cyc %0d got %b exp %b", r, host_gnt, gnt_tab[r]);
            end
            checks++;
            if (gnt_tab[r]) begin
                if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL arb_host_wr cyc %0d got en=%b we=%b exp 1 1", r, mem_en, mem_we); end
            end else begin
                if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 3'(rd)) begin
                    errors++; $display("FAIL arb_disp_rd cyc %0d got en=%b we=%b addr=%0d exp 1 0 %0d", r, mem_en, mem_we, mem_addr, rd);
                end
                rd++;
            end
            checks++;
            if (line_buffer_vld !== vld_tab[r] || (vld_tab[r] && line_buffer_data !== pix(pk))) begin
                errors++; $display("FAIL arb_out cyc %0d got vld=%b data=%h exp vld=%b data=%h", r, line_buffer_vld, line_buffer_data, vld_tab[r], pix(pk));
            end
            if (vld_tab[r]) pk++;
        end
        host_req = 1'b0;
    endtask

    task automatic test_enable_drop();
        int n;
        n = 0;
        do_reset();
        fb_enable = 1'b1; line_buffer_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge sys_clk);
            if (i == 3) fb_enable = 1'b0;
            #1;
            checks++;
            if (i <= 8) begin
                if (mem_en !== 1'b1 || mem_addr !== 3'(i - 1)) begin
                    errors++; $display("FAIL drop_read cyc %0d got en=%b addr=%0d exp en=1 addr=%0d", i, mem_en, mem_addr, i - 1);
                end
            end else if (mem_en !== 1'b0) begin
                errors++; $display("FAIL drop_idle cyc %0d got en=%b exp 0", i, mem_en);
            end
            if (line_buffer_vld === 1'b1) begin
                checks++;
                if (line_buffer_data !== pix(n)) begin
                    errors++; $display("FAIL drop_data idx %0d got %h exp %h", n, line_buffer_data, pix(n));
                end
                n++;
            end
        end
        checks++;
        if (n != 8) begin errors++; $display("FAIL drop_count got %0d exp 8", n); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fb_enable = 1'b1; line_buffer_rdy = 1'b1;
        @(negedge sys_clk); #1;
        checks++; if (mem_en !== 1'b1 || mem_addr !== 3'd0) begin errors++; $display("FAIL rstmid_first got en=%b addr=%0d exp 1 0", mem_en, mem_addr); end
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        checks++; if (line_buffer_vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld got %b exp 0", line_buffer_vld); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rstmid_en got %b exp 0", mem_en); end
        @(negedge sys_clk); #1;
        checks++; if (mem_en !== 1'b1 || mem_addr !== 3'd0) begin errors++; $display("FAIL rstmid_restart got en=%b addr=%0d exp 1 0", mem_en, mem_addr); end
        @(negedge sys_clk); #1;
        checks++; if (line_buffer_vld !== 1'b0) begin errors++; $display("FAIL rstmid_stale got vld=%b exp 0", line_buffer_vld); end
        @(negedge sys_clk); #1;
        checks++;
        if (line_buffer_vld !== 1'b1 || line_buffer_data !== pix(0)) begin
            errors++; $display("FAIL rstmid_sof got vld=%b data=%h exp vld=1 data=%h", line_buffer_vld, line_buffer_data, pix(0));
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_backpressure();
        test_host_arb();
        test_enable_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
